// File: rtl/fp_pkg.sv
// Shared widths, exponent constants and state encoding for the
// iterative single-precision FP units.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 27;
    localparam int ADD_W  = 29;

    localparam logic [EXP_W-1:0] EXP_DENORM = 8'd1;
    localparam logic [EXP_W-1:0] EXP_INF    = 8'd255;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } fp_sub_state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even on a {hidden, frac, G, R, S} mantissa and pack
// into an IEEE754 single, handling denormal promotion and overflow.
module fp_round_pack
    import fp_pkg::*;
(
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [MANT_W-1:0] mant_i,
    output logic [31:0]       word_o
);

    logic              up;
    logic [24:0]       rnd;
    logic [EXP_W:0]    efield;
    logic [EXP_W:0]    eout;
    logic [FRAC_W-1:0] frac;

    always_comb begin
        up = (mant_i[2:0] > 3'd4) || ((mant_i[2:0] == 3'd4) && mant_i[3]);
        rnd = {1'b0, mant_i[MANT_W-1:3]} + {24'd0, up};
        // No hidden bit means a denormal (or zero): field is 0 until
        // rounding carries into the hidden position.
        efield = mant_i[MANT_W-1] ? {1'b0, exp_i} : '0;
        eout = efield
             + {{EXP_W{1'b0}}, rnd[24] | (rnd[23] & ~mant_i[MANT_W-1])};
        frac = rnd[24] ? rnd[23:1] : rnd[22:0];
        if (eout >= {1'b0, EXP_INF}) begin
            word_o = {sign_i, EXP_INF, {FRAC_W{1'b0}}};
        end else begin
            word_o = {sign_i, eout[EXP_W-1:0], frac};
        end
    end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Iterative IEEE754 single-precision subtractor d = a - b using
// one-bit-per-cycle alignment and normalization shifts.
module fp_subtractor_seq
    import fp_pkg::*;
#(
    parameter int MAX_ALIGN = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d
);

    localparam int CNT_W = $clog2(MAX_ALIGN + 1);
    localparam logic [CNT_W-1:0] K_MAX = CNT_W'(MAX_ALIGN);

    fp_sub_state_t state_q, state_d;

    logic              sgn_big_q, sgn_big_d;
    logic              sgn_sml_q, sgn_sml_d;
    logic              res_sgn_q, res_sgn_d;
    logic [MANT_W-1:0] big_q, big_d;
    logic [MANT_W-1:0] sml_q, sml_d;
    logic [MANT_W:0]   res_q, res_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       d_q, d_d;

    logic [EXP_W-1:0]  ea, eb, diff;
    logic [MANT_W-1:0] ma, mb;
    logic              a_big;
    logic [CNT_W-1:0]  k;
    logic [ADD_W-1:0]  va, vb, sum, mag;
    logic [31:0]       packed_w;

    always_comb begin
        ea = (a[30:23] == '0) ? EXP_DENORM : a[30:23];
        eb = (b[30:23] == '0) ? EXP_DENORM : b[30:23];
        ma = {|a[30:23], a[22:0], 3'b000};
        mb = {|b[30:23], b[22:0], 3'b000};
        a_big = ea >= eb;
        diff = a_big ? ea - eb : eb - ea;
        k = (int'(diff) > MAX_ALIGN) ? K_MAX : diff[CNT_W-1:0];
    end

    // Two's complement add of sign-magnitude mantissas
    always_comb begin
        va = {2'b00, big_q};
        vb = {2'b00, sml_q};
        if (sgn_big_q) va = ~va + ADD_W'(1);
        if (sgn_sml_q) vb = ~vb + ADD_W'(1);
        sum = va + vb;
        mag = sum[ADD_W-1] ? ~sum + ADD_W'(1) : sum;
    end

    fp_round_pack u_round (
        .sign_i (res_sgn_q),
        .exp_i  (exp_q),
        .mant_i (res_q[MANT_W-1:0]),
        .word_o (packed_w)
    );

    always_comb begin
        state_d   = state_q;
        sgn_big_d = sgn_big_q;
        sgn_sml_d = sgn_sml_q;
        res_sgn_d = res_sgn_q;
        big_d     = big_q;
        sml_d     = sml_q;
        res_d     = res_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sgn_big_d = a_big ? a[31] : ~b[31];
                    sgn_sml_d = a_big ? ~b[31] : a[31];
                    big_d     = a_big ? ma : mb;
                    sml_d     = a_big ? mb : ma;
                    exp_d     = a_big ? ea : eb;
                    cnt_d     = k;
                    state_d   = (k != '0) ? S_ALIGN : S_ADD;
                end
            end
            S_ALIGN: begin
                sml_d = {1'b0, sml_q[MANT_W-1:1]};
                sml_d[0] = sml_q[1] | sml_q[0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_ADD;
            end
            S_ADD: begin
                res_sgn_d = sum[ADD_W-1];
                res_d     = mag[MANT_W:0];
                if (mag == '0) begin
                    res_sgn_d = 1'b0;
                    exp_d     = '0;
                    state_d   = S_ROUND;
                end else if (mag[MANT_W]) begin
                    state_d = S_NORM;
                end else if (mag[MANT_W-1] || exp_q == EXP_DENORM) begin
                    state_d = S_ROUND;
                end else begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (res_q[MANT_W]) begin
                    res_d = {1'b0, res_q[MANT_W:2], res_q[1] | res_q[0]};
                    exp_d = exp_q + EXP_W'(1);
                    state_d = S_ROUND;
                end else begin
                    res_d = {res_q[MANT_W-1:0], 1'b0};
                    exp_d = exp_q - EXP_W'(1);
                    if (res_q[MANT_W-2] || exp_q == EXP_W'(2)) begin
                        state_d = S_ROUND;
                    end
                end
            end
            S_ROUND: begin
                d_d     = packed_w;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sgn_big_q <= 1'b0;
            sgn_sml_q <= 1'b0;
            res_sgn_q <= 1'b0;
            big_q     <= '0;
            sml_q     <= '0;
            res_q     <= '0;
            exp_q     <= '0;
            cnt_q     <= '0;
            d_q       <= '0;
        end else begin
            state_q   <= state_d;
            sgn_big_q <= sgn_big_d;
            sgn_sml_q <= sgn_sml_d;
            res_sgn_q <= res_sgn_d;
            big_q     <= big_d;
            sml_q     <= sml_d;
            res_q     <= res_d;
            exp_q     <= exp_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign d         = d_q;

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Scoreboard bench for fp_subtractor_seq: directed vectors, backpressure,
// mid-operation reset and randomized operands against an exact-arithmetic model.
module tb_fp_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] d;

    always #5 clk = ~clk;

    fp_subtractor_seq #(.MAX_ALIGN(27)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        longint      t0;
    } exp_t;

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;
    bit     seen = 0;
    bit     rand_rdy = 0;
    logic   rdy_force = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Exact value arithmetic: operands as integer * 2^(e-150), then RNE.
    function automatic logic [31:0] ref_sub(input logic [31:0] x,
                                            input logic [31:0] y);
        logic [127:0] ma, mb, av, bv, mag, q, rem, half, one;
        logic         sa, sb, sr;
        int           ea, eb, base, p, e, sh;
        one = 128'd1;
        ea = (x[30:23] == 0) ? 1 : int'(x[30:23]);
        eb = (y[30:23] == 0) ? 1 : int'(y[30:23]);
        ma = {104'd0, x[30:23] != 0, x[22:0]};
        mb = {104'd0, y[30:23] != 0, y[22:0]};
        sa = x[31];
        sb = ~y[31];
        if (ea - eb > 70) begin
            av = ma << 40; bv = (mb != 0) ? one : 0; base = ea - 40;
        end else if (eb - ea > 70) begin
            bv = mb << 40; av = (ma != 0) ? one : 0; base = eb - 40;
        end else if (ea >= eb) begin
            av = ma << (ea - eb); bv = mb; base = eb;
        end else begin
            bv = mb << (eb - ea); av = ma; base = ea;
        end
        if (sa == sb) begin
            mag = av + bv; sr = sa;
        end else if (av >= bv) begin
            mag = av - bv; sr = sa;
        end else begin
            mag = bv - av; sr = sb;
        end
        if (mag == 0) return 32'h0;
        p = 0;
        for (int i = 127; i >= 0; i--) begin
            if (mag[i]) begin p = i; break; end
        end
        e = base + p - 23;
        if (e < 1) e = 1;
        sh = e - base;
        if (sh > 0) begin
            q = mag >> sh;
            rem = mag & ((one << sh) - one);
            half = one << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + one;
        end else begin
            q = mag << (-sh);
        end
        if (q[24]) begin
            q = q >> 1; e = e + 1;
        end
        if (!q[23]) e = 0;
        if (e >= 255) return {sr, 8'hFF, 23'h0};
        return {sr, 8'(e), q[22:0]};
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got d=%h with nothing pending", d);
            end else begin
                if (!seen) begin
                    seen = 1;
                    if (sb_q[0].lat > 0)
                        check("latency", 32'(cyc - sb_q[0].t0), 32'(sb_q[0].lat));
                end
                if (out_ready) begin
                    check("d", d, sb_q[0].res);
                    void'(sb_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] want, input int lat);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
            return;
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        sb_q.push_back('{res: want, lat: lat, t0: cyc});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got %0d pending want 0", sb_q.size());
            sb_q.delete();
            seen = 0;
        end
    endtask

    task automatic rand_ops(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [31:0] x, y;
            int e;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 4))
                0: e = int'(x[30:23]);
                1: e = int'(x[30:23]) + int'($urandom_range(0, 60)) - 30;
                2: begin
                    e = int'(x[30:23]);
                    y[22:8] = x[22:8];
                    y[31] = x[31];
                end
                3: begin
                    x[30:23] = 8'($urandom_range(0, 2));
                    e = int'($urandom_range(0, 2));
                end
                default: e = int'(y[30:23]);
            endcase
            if (e < 0) e = 0;
            if (e > 254) e = 254;
            y[30:23] = 8'(e);
            if (x[30:23] == 8'hFF) x[30:23] = 8'hFE;
            send(x, y, ref_sub(x, y), -1);
            wait_done();
        end
    endtask

    localparam int ND = 14;
    logic [31:0] dir_a [ND] = '{
        32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800001,
        32'h00800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
        32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000, 32'h00000001,
        32'h3F800000, 32'hC0000000};
    logic [31:0] dir_b [ND] = '{
        32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
        32'h00400000, 32'h33800000, 32'hB3800000, 32'hF2000000,
        32'hF3000000, 32'hFF7FFFFF, 32'h00000000, 32'h00000002,
        32'h00000001, 32'hC0400000};
    logic [31:0] dir_d [ND] = '{
        32'h40000000, 32'h00000000, 32'h40000000, 32'h34000000,
        32'h00400000, 32'h3F7FFFFF, 32'h3F800000, 32'h7F7FFFFF,
        32'h7F800000, 32'h7F800000, 32'h00000000, 32'h80000001,
        32'h3F800000, 32'h3F800000};
    int dir_l [ND] = '{4, 3, 4, 26, 3, 28, 27, 29, 27, 4, 3, 3, 31, 4};

    initial begin
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_d", d, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < ND; i++) begin
            send(dir_a[i], dir_b[i], dir_d[i], dir_l[i]);
            wait_done();
        end

        rdy_force = 1'b0;
        send(32'h40400000, 32'h3F800000, 32'h40000000, 4);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0] ? 1'b0 : 1'b1;
            a = 32'h41200000;
            b = 32'h40A00000;
            #3;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_d", d, 32'h40000000);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rdy_force = 1'b1;
        @(negedge clk);
        #3;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        wait_done();

        send(32'h49800000, 32'h3F800000, 32'h0, -1);
        repeat (5) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_d", d, 32'd0);
        sb_q.delete();
        seen = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h40400000, 32'h3F800000, 32'h40000000, 4);
        wait_done();

        rand_rdy = 1;
        rand_ops(250);
        rand_rdy = 0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
